// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master issues start with operands and mode; the slave returns
// status, the parallel result, carry/borrow and a completion pulse.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             k;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             done;

  modport master (
    output start, k, a, b,
    input  ready, busy, s, c, done
  );

  modport slave (
    input  start, k, a, b,
    output ready, busy, s, c, done
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial N-bit adder/subtractor: one 1-bit add/sub cell plus a
// carry/borrow flop, fed LSB first from operand shift registers.
// The result is assembled MSB-inward and published on the completion edge.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_sub_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   aShift_q;
  logic [WIDTH-1:0]   bShift_q;
  logic [WIDTH-2:0]   partial_q;
  logic               carry_q;
  logic               mode_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   sOut_q;
  logic               cOut_q;
  logic               done_q;

  logic               ai;
  logic               bi;
  logic               ci;
  logic               sumBit_d;
  logic               carry_d;
  logic [WIDTH-1:0]   result_d;
  logic [CNT_W-1:0]   count_d;

  // The 1-bit add/sub cell: sum bit and next carry (or borrow) for this step.
  always_comb begin
    ai       = aShift_q[0];
    bi       = bShift_q[0];
    ci       = carry_q;
    sumBit_d = ai ^ bi ^ ci;
    if (mode_q) begin
      carry_d = (~ai & bi) | (~(ai ^ bi) & ci);
    end else begin
      carry_d = (ai & bi) | (ai & ci) | (bi & ci);
    end
    result_d = {sumBit_d, partial_q};
    count_d  = count_q + CNT_W'(1);
  end

  // Sequencer: accept operands, step the cell once per edge, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aShift_q  <= '0;
      bShift_q  <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      count_q   <= '0;
      sOut_q    <= '0;
      cOut_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            aShift_q <= bus.a;
            bShift_q <= bus.b;
            mode_q   <= bus.k;
            carry_q  <= 1'b0;
            count_q  <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          aShift_q  <= aShift_q >> 1;
          bShift_q  <= bShift_q >> 1;
          partial_q <= result_d[WIDTH-1:1];
          carry_q   <= carry_d;
          count_q   <= count_d;
          if (count_d == CNT_W'(WIDTH)) begin
            sOut_q  <= result_d;
            cOut_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            aShift_q <= bus.a;
            bShift_q <= bus.b;
            mode_q   <= bus.k;
            carry_q  <= 1'b0;
            count_q  <= '0;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = (state_q != RUN);
  assign bus.busy  = (state_q == RUN);
  assign bus.s     = sOut_q;
  assign bus.c     = cOut_q;
  assign bus.done  = done_q;

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial N-bit adder/subtractor built around a single 1-bit add/sub cell plus a carry/borrow flop.
- Accepts two parallel operands and a mode bit k (0 = add, 1 = subtract a-b), then processes one bit per clock, LSB first.
- Returns a parallel result with carry-out/borrow-out and a completion pulse.
- Acts as the sequencing stage directly upstream of the 1-bit cell: it feeds the cell bit pairs and carry, and collects its sum and carry.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted on a rising edge when ready=1.
- k  input  1  mode: 0 = a+b, 1 = a-b; sampled on accept.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- ready  output  1  high in IDLE and DONE; combinational from state.
- busy  output  1  high in RUN.
- s  output  WIDTH  result, registered; changes only on the completion edge.
- c  output  1  carry-out (k=0) or borrow-out (k=1); registered with s.
- done  output  1  one-cycle pulse; s and c are valid from this cycle on.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, s=0, c=0, done=0, busy=0, ready=1, counter=0, carry flop=0, shift regs=0. Applies immediately, including mid-operation. The in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch a, b and k into internal shift regs and the mode reg, set carry flop=0 and counter=0, then go to RUN.
- RUN: ready=0, busy=1, start is ignored. Each edge takes ai=A[0], bi=B[0], ci=carry flop.
  - k=0: r = ai^bi^ci; co = (ai&bi)|(ai&ci)|(bi&ci).
  - k=1: r = ai^bi^ci; co = (~ai&bi)|(~(ai^bi)&ci), where ci is the borrow.
  - Shift A and B right by 1. Shift r into the MSB of the internal result reg. Carry flop := co. Counter += 1.
  - On the edge where the counter reaches WIDTH: s := full internal result, c := co, done := 1, go to DONE.
- DONE: lasts exactly one cycle. done=1, ready=1, busy=0.
  - start=1 is accepted on the same edge (back-to-back), with IDLE-accept semantics, and the block goes to RUN.
  - Otherwise the block goes to IDLE. done drops to 0 on that edge in either case.
- Latency: on accept at edge E0, bits are processed on E1..E_WIDTH, and s/c/done update on E_WIDTH. Throughput is one operation per WIDTH+1 cycles with start held high.
- s and c hold their last values until the next completion. They are not cleared on accept.
- Arithmetic is modulo 2^WIDTH. Subtract underflow produces the two's-complement result with c=1. There is no overflow flag.
- Inputs a, b and k may change freely after accept without affecting the result.

Test Plan:
- WIDTH=8, k=0, a=0x3C, b=0x0F, start pulse at E0 -> s=0x4B, c=0, done high for exactly one cycle after E8, busy high E1..E7 then low.
- k=0, a=0xFF, b=0x01 -> s=0x00, c=1. Then k=0, a=0x00, b=0x00 -> s=0x00, c=0.
- k=1, a=0x50, b=0x20 -> s=0x30, c=0. Then k=1, a=0x20, b=0x50 -> s=0xD0, c=1.
- k=0, a=0x11, b=0x22 accepted; during RUN, start=1 with a=0xFF, b=0xFF, k=1 -> ignored; s=0x33, c=0; a/b changes mid-run have no effect.
- After accept of a=0xAA, b=0x55, assert rst_n=0 after E4 -> s=0, c=0, done=0, busy=0, ready=1 asynchronously; no done pulse follows. After release, k=0, a=0x01, b=0x01 -> s=0x02, c=0.
- start held high continuously with (k=0, 0x10, 0x20) then (k=1, 0x05, 0x07) presented in the DONE cycle -> done pulses 9 cycles apart; s=0x30, c=0 then s=0xFE, c=1.
